// File: rtl/scan_display_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan scheduler.
package scan_display_ctrl_pkg;

  localparam int unsigned N_DIGITS = 4;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEL_W    = $clog2(N_DIGITS);
  localparam int unsigned DATA_W   = N_DIGITS * NIBBLE_W;

  localparam logic [N_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef enum logic {
    ST_BLANK,
    ST_LIT
  } scan_state_t;

  // Active-low one-hot anode pattern for the given digit index.
  function automatic logic [N_DIGITS-1:0] anode_on(input logic [SEL_W-1:0] sel);
    return ~(N_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Valid/ready load channel carrying four BCD nibbles into the scan scheduler.
interface scan_display_ctrl_if;
  import scan_display_ctrl_pkg::*;

  logic [DATA_W-1:0] i_Data;
  logic              i_Valid;
  logic              o_Ready;

  modport master (output i_Data, output i_Valid, input  o_Ready);
  modport slave  (input  i_Data, input  i_Valid, output o_Ready);

endinterface

// File: rtl/scan_display_ctrl_slot_timer.sv
// Slot counter and digit index; emits slot/blank/frame boundary strobes.
module scan_display_ctrl_slot_timer
  import scan_display_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  output logic [SEL_W-1:0] o_Sel,
  output logic [SEL_W-1:0] o_SelNext,
  output logic             o_SlotStart,
  output logic             o_BlankDone,
  output logic             o_SlotEnd,
  output logic             o_FrameEnd
);

  localparam int unsigned      CNT_W      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(N_DIGITS - 1);

  logic [CNT_W-1:0] r_Count;
  logic [SEL_W-1:0] r_Sel;
  logic             r_FrameEnd;

  logic             w_Wrap;
  logic [CNT_W-1:0] w_CountNext;
  logic [SEL_W-1:0] w_SelNext;

  always_comb begin
    w_Wrap      = (r_Count == LAST_CNT);
    w_CountNext = w_Wrap ? '0 : r_Count + 1'b1;
    w_SelNext   = w_Wrap ? r_Sel + 1'b1 : r_Sel;
  end

  // Frame-end strobe is decoded from next-cycle values so it is a clean flop aligned with the count.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Count    <= '0;
      r_Sel      <= '0;
      r_FrameEnd <= 1'b0;
    end else begin
      r_Count    <= w_CountNext;
      r_Sel      <= w_SelNext;
      r_FrameEnd <= (w_CountNext == LAST_CNT) && (w_SelNext == LAST_SEL);
    end
  end

  assign o_Sel       = r_Sel;
  assign o_SelNext   = w_SelNext;
  assign o_SlotStart = (r_Count == '0);
  assign o_BlankDone = (r_Count == BLANK_LAST);
  assign o_SlotEnd   = w_Wrap;
  assign o_FrameEnd  = r_FrameEnd;

endmodule

// File: rtl/scan_display_ctrl.sv
// 4-digit multiplexed display scan scheduler with blanking guard, digit mask,
// frame-level brightness PWM and frame-synchronous digit update via valid/ready.
module scan_display_ctrl
  import scan_display_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 500,
  parameter int unsigned BRIGHT_W  = 4
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  scan_display_ctrl_if.slave  s_Bus,
  input  logic [N_DIGITS-1:0] i_Enable,
  input  logic [BRIGHT_W-1:0] i_Bright,
  output logic [SEL_W-1:0]    o_Sel,
  output logic [N_DIGITS-1:0] o_Anodos,
  output logic [NIBBLE_W-1:0] o_Digit,
  output logic                o_FrameEnd
);

  logic [SEL_W-1:0] w_Sel;
  logic [SEL_W-1:0] w_SelNext;
  logic             w_SlotStart;
  logic             w_BlankDone;
  logic             w_SlotEnd;
  logic             w_FrameEnd;

  scan_display_ctrl_slot_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_slot_timer (
    .i_Clk       (i_Clk),
    .i_Reset     (i_Reset),
    .o_Sel       (w_Sel),
    .o_SelNext   (w_SelNext),
    .o_SlotStart (w_SlotStart),
    .o_BlankDone (w_BlankDone),
    .o_SlotEnd   (w_SlotEnd),
    .o_FrameEnd  (w_FrameEnd)
  );

  scan_state_t         r_State;
  scan_state_t         w_StateNext;
  logic                r_SlotOn;
  logic [BRIGHT_W-1:0] r_Pwm;
  logic                r_Ready;
  logic [DATA_W-1:0]   r_Hold;
  logic [DATA_W-1:0]   r_Disp;
  logic [N_DIGITS-1:0] r_Anodos;
  logic [NIBBLE_W-1:0] r_Digit;

  logic                w_FrameLit;
  logic                w_SlotOn;
  logic                w_Accept;
  logic                w_Transfer;
  logic [DATA_W-1:0]   w_DispNext;
  logic [N_DIGITS-1:0] w_AnodosNext;

  always_comb begin
    w_StateNext = r_State;
    unique case (r_State)
      ST_BLANK: if (w_BlankDone) w_StateNext = ST_LIT;
      ST_LIT:   if (w_SlotEnd)   w_StateNext = ST_BLANK;
      default:                   w_StateNext = ST_BLANK;
    endcase
  end

  // The lit decision is taken during slot cycle 0 and held, so mid-slot input changes wait a slot.
  always_comb begin
    w_FrameLit   = (i_Bright == '1) || (r_Pwm < i_Bright);
    w_SlotOn     = w_SlotStart ? (i_Enable[w_Sel] & w_FrameLit) : r_SlotOn;
    w_Accept     = s_Bus.i_Valid & r_Ready;
    w_Transfer   = w_FrameEnd & ~r_Ready;
    w_DispNext   = w_Transfer ? r_Hold : r_Disp;
    w_AnodosNext = ANODE_OFF;
    if (w_StateNext == ST_LIT && w_SlotOn)
      w_AnodosNext = anode_on(w_SelNext);
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State  <= ST_BLANK;
      r_SlotOn <= 1'b0;
      r_Pwm    <= '0;
      r_Anodos <= ANODE_OFF;
      r_Digit  <= '0;
    end else begin
      r_State  <= w_StateNext;
      r_SlotOn <= w_SlotOn;
      if (w_FrameEnd)
        r_Pwm <= r_Pwm + 1'b1;
      r_Anodos <= w_AnodosNext;
      r_Digit  <= w_DispNext[{w_SelNext, 2'b00} +: NIBBLE_W];
    end
  end

  // Accept and transfer are exclusive: one needs the holding register empty, the other full.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Ready <= 1'b1;
      r_Hold  <= '0;
      r_Disp  <= '0;
    end else begin
      if (w_Transfer) begin
        r_Disp  <= r_Hold;
        r_Ready <= 1'b1;
      end else if (w_Accept) begin
        r_Hold  <= s_Bus.i_Data;
        r_Ready <= 1'b0;
      end
    end
  end

  assign s_Bus.o_Ready = r_Ready;
  assign o_Sel         = w_Sel;
  assign o_Anodos      = r_Anodos;
  assign o_Digit       = r_Digit;
  assign o_FrameEnd    = w_FrameEnd;

endmodule

// File: tb/tb_scan_display_ctrl.sv
// Scoreboard bench for scan_display_ctrl with CLK_DIV=8, BLANK_CYC=2, BRIGHT_W=2.
module tb_scan_display_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] enable;
  logic [1:0] bright;
  logic [1:0] sel;
  logic [3:0] anodos;
  logic [3:0] digit;
  logic       frame_end;

  scan_display_ctrl_if bus ();

  scan_display_ctrl #(
    .CLK_DIV   (8),
    .BLANK_CYC (2),
    .BRIGHT_W  (2)
  ) dut (
    .i_Clk      (clk),
    .i_Reset    (rst),
    .s_Bus      (bus),
    .i_Enable   (enable),
    .i_Bright   (bright),
    .o_Sel      (sel),
    .o_Anodos   (anodos),
    .o_Digit    (digit),
    .o_FrameEnd (frame_end)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles elapsed since the most recent reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  typedef struct {
    int         at;
    logic [1:0] sel;
    logic [3:0] an;
    logic [3:0] dig;
    logic       rdy;
    logic       fe;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input int at, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, at, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].at == cyc) begin
        check("sel",      cyc, {2'b00, sel},            {2'b00, q[0].sel});
        check("anodos",   cyc, anodos,                  q[0].an);
        check("digit",    cyc, digit,                   q[0].dig);
        check("ready",    cyc, {3'b000, bus.o_Ready},   {3'b000, q[0].rdy});
        check("frameend", cyc, {3'b000, frame_end},     {3'b000, q[0].fe});
        void'(q.pop_front());
      end else if (q[0].at < cyc) begin
        n_checks++;
        n_errors++;
        $display("FAIL missed_sample cycle %0d: got cycle %0d expected cycle %0d", q[0].at, cyc, q[0].at);
        void'(q.pop_front());
      end
    end
  end

  // Expected scan for cycles t_from..t_to: 8-cycle slots, 2 blank cycles, digit order 0..3.
  task automatic expect_range(input int t_from, input int t_to, input logic [15:0] disp,
                              input logic [3:0] en, input bit lit, input bit rdy);
    logic [3:0] lit_tbl [4];
    exp_t e;
    lit_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int t = t_from; t <= t_to; t++) begin
      int cnt;
      int s;
      cnt   = t % 8;
      s     = (t / 8) % 4;
      e.at  = t;
      e.sel = 2'(s);
      e.an  = (cnt >= 2 && en[s] && lit) ? lit_tbl[s] : 4'b1111;
      e.dig = disp[4*s +: 4];
      e.rdy = rdy;
      e.fe  = (cnt == 7 && s == 3);
      q.push_back(e);
    end
  endtask

  task automatic expect_reset();
    exp_t e;
    e.at  = 0;
    e.sel = 2'd0;
    e.an  = 4'b1111;
    e.dig = 4'h0;
    e.rdy = 1'b1;
    e.fe  = 1'b0;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst         = 1'b1;
    enable      = 4'hF;
    bright      = 2'd3;
    bus.i_Valid = 1'b0;
    bus.i_Data  = 16'h0000;
    expect_reset();
    repeat (3) @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.i_Valid = 1'b1;
    bus.i_Data  = 16'h4321;

    // Frames are 32 cycles: frame f spans 32f..32f+31.
    expect_range(  1,  31, 16'h0000, 4'hF, 1'b1, 1'b0);  // loading 4321, not yet shown
    expect_range( 32,  40, 16'h4321, 4'hF, 1'b1, 1'b1);  // scan order 1,2,3,4
    expect_range( 41,  63, 16'h4321, 4'hF, 1'b1, 1'b0);  // 9876 pending
    expect_range( 64,  95, 16'h9876, 4'hF, 1'b1, 1'b1);
    expect_range( 96, 127, 16'h9876, 4'hF, 1'b1, 1'b0);  // beat taken on frame-end cycle
    expect_range(128, 159, 16'hABCD, 4'h5, 1'b1, 1'b1);  // mask 0101
    expect_range(160, 175, 16'hABCD, 4'h5, 1'b1, 1'b1);  // sel1 stays dark after mid-slot enable
    expect_range(176, 191, 16'hABCD, 4'hF, 1'b1, 1'b1);
    expect_range(192, 255, 16'hABCD, 4'hF, 1'b0, 1'b1);  // bright=1, pwm 2,3
    expect_range(256, 287, 16'hABCD, 4'hF, 1'b1, 1'b1);  // pwm 0 -> lit
    expect_range(288, 319, 16'hABCD, 4'hF, 1'b0, 1'b1);
    expect_range(320, 447, 16'hABCD, 4'hF, 1'b0, 1'b1);  // bright=0 never lit
    expect_range(448, 490, 16'hABCD, 4'hF, 1'b1, 1'b1);  // bright=3 always lit
    expect_range(491, 500, 16'hABCD, 4'hF, 1'b1, 1'b0);

    wait_until(1);
    bus.i_Valid = 1'b0;
    wait_until(40);
    bus.i_Valid = 1'b1;
    bus.i_Data  = 16'h9876;
    wait_until(41);
    bus.i_Valid = 1'b0;
    wait_until(45);
    bus.i_Valid = 1'b1;
    bus.i_Data  = 16'h5555;
    wait_until(48);
    bus.i_Valid = 1'b0;
    wait_until(95);
    bus.i_Valid = 1'b1;
    bus.i_Data  = 16'hABCD;
    wait_until(96);
    bus.i_Valid = 1'b0;
    wait_until(128);
    enable = 4'b0101;
    wait_until(170);
    enable = 4'hF;
    wait_until(192);
    bright = 2'd1;
    wait_until(320);
    bright = 2'd0;
    wait_until(448);
    bright = 2'd3;
    wait_until(490);
    bus.i_Valid = 1'b1;
    bus.i_Data  = 16'h1234;
    wait_until(491);
    bus.i_Valid = 1'b0;

    // Reset at sel=2, slot cycle 5 (480+16+5).
    wait_until(501);
    expect_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    expect_range(1, 39, 16'h0000, 4'hF, 1'b1, 1'b1);
    wait_until(42);

    if (q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL queue_drain: got %0d pending entries expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
